// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: the ALU op codes and
// the arbiter FSM state encoding.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kSUB  = 3'd1,
    kAND  = 3'd2,
    kOR   = 3'd3,
    kXOR  = 3'd4,
    kLSOR = 3'd5,
    kINC  = 3'd6,
    kPASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the requester that was
// not granted last time wins; a lone requester always wins.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = |valid;
    grant_idx = (valid == 2'b11) ? ~last : valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU between the execute stage (requester 0)
// and the parity/branch helper (requester 1), one operation at a time.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqValid0,
  input  logic                ReqValid1,
  output logic                ReqReady0,
  output logic                ReqReady1,
  input  logic [OP_W-1:0]     ReqOP0,
  input  logic [OP_W-1:0]     ReqOP1,
  input  logic [DATA_W-1:0]   ReqA0,
  input  logic [DATA_W-1:0]   ReqB0,
  input  logic [DATA_W-1:0]   ReqA1,
  input  logic [DATA_W-1:0]   ReqB1,
  output logic                RspValid0,
  output logic                RspValid1,
  input  logic                RspAck0,
  input  logic                RspAck1,
  output logic [DATA_W-1:0]   RspOut,
  output logic                RspZero,
  output logic                RspParity,
  output logic [OP_W-1:0]     AluOP,
  output logic [DATA_W-1:0]   AluA,
  output logic [DATA_W-1:0]   AluB,
  input  logic [DATA_W-1:0]   AluOut,
  input  logic                AluZero,
  input  logic                AluParity,
  output logic [1:0]          dbg_state
);

  // Handshakes: a request transfers in a cycle where ReqValidN && ReqReadyN;
  // ReqReady is only ever raised in IDLE and for at most one requester. A
  // response is offered while RspValidN is high and is consumed in the cycle
  // RspAckN is high; the non-granted requester's ack has no effect.

  arb_state_t        state, state_nxt;
  logic              last;
  logic              gnt_idx;
  logic              pick_grant;
  logic              pick_idx;
  logic              accept;
  logic              rsp_ack;
  logic [OP_W-1:0]   cap_op;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic [DATA_W-1:0] res_out;
  logic              res_zero;
  logic              res_parity;

  alu_rr_pick u_pick (
    .valid     ({ReqValid1, ReqValid0}),
    .last      (last),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Gating with Reset keeps ReqReady low while reset is held.
  assign accept    = (state == IDLE) && pick_grant && !Reset;
  assign ReqReady0 = accept && !pick_idx;
  assign ReqReady1 = accept && pick_idx;
  assign rsp_ack   = gnt_idx ? RspAck1 : RspAck0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt_idx    <= 1'b0;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      res_out    <= '0;
      res_zero   <= 1'b0;
      res_parity <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_idx <= pick_idx;
        last    <= pick_idx;
        cap_op  <= pick_idx ? ReqOP1 : ReqOP0;
        cap_a   <= pick_idx ? ReqA1 : ReqA0;
        cap_b   <= pick_idx ? ReqB1 : ReqB0;
      end
      if (state == EXEC) begin
        res_out    <= AluOut;
        res_zero   <= AluZero;
        res_parity <= AluParity;
      end
    end
  end

  // The capture registers double as the ALU drive registers.
  assign AluOP     = cap_op;
  assign AluA      = cap_a;
  assign AluB      = cap_b;
  assign RspValid0 = (state == RESP) && !gnt_idx;
  assign RspValid1 = (state == RESP) && gnt_idx;
  assign RspOut    = res_out;
  assign RspZero   = res_zero;
  assign RspParity = res_parity;
  assign dbg_state = state;

endmodule
